// File: rtl/ena_run_trigger.sv
// ---------------------------------------------------------------------------
// ena_run_trigger
//
// Multi-channel run-length trigger. Every channel counts consecutive clock
// cycles on which its enable is sampled high. Once the run reaches the shared
// runtime threshold, the channel raises its trigger. The trigger shape
// depends on the mode:
//   0 = one-shot, 1 = level, 2 = periodic, 3 = reserved (acts as one-shot).
// A sticky hit flag per channel records that a trigger occurred. The
// current run count of every channel is visible on a flat output bus.
//
// Parameters
//   CH      number of independent channels (1..16)
//   CNT_W   width of the threshold and of each per-channel run counter
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       asynchronous, active-high reset
//   i_ena       per-channel enable; bit i feeds channel i
//   i_thresh    run length that fires a trigger, shared by all channels
//   i_mode      trigger mode (see above), sampled every cycle
//   i_hit_clr   per-channel clear of the sticky hit flag
//   o_trigger   per-channel registered trigger
//   o_hit       per-channel sticky hit flag
//   o_run_cnt   per-channel run count; channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module ena_run_trigger #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CH-1:0]         i_ena,
  input  logic [CNT_W-1:0]      i_thresh,
  input  logic [1:0]            i_mode,
  input  logic [CH-1:0]         i_hit_clr,
  output logic [CH-1:0]         o_trigger,
  output logic [CH-1:0]         o_hit,
  output logic [CH*CNT_W-1:0]   o_run_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Mode decode is shared by every channel. Reserved mode 3 falls through to
  // the one-shot behaviour because neither decode is true for it.
  logic w_levelMode;
  logic w_periodicMode;

  assign w_levelMode    = (i_mode == 2'd1);
  assign w_periodicMode = (i_mode == 2'd2);

  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : gChannel

      logic [CNT_W-1:0] r_cnt;
      state_t           r_state;
      logic             r_trig;
      logic             r_hit;

      logic [CNT_W-1:0] w_nxt;
      logic             w_match;
      logic             w_trigNext;

      // Saturating increment. The counter never wraps, so a very long run
      // can never alias back onto a small threshold and fire a second time.
      assign w_nxt = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));

      // w_nxt is at least 1, so a zero threshold can never match. That
      // disables the channel while still letting it count.
      assign w_match = (w_nxt == i_thresh);

      // The next trigger value is needed twice: once as the registered
      // trigger and once to set the sticky hit flag on the same edge.
      // Level mode only holds a trigger that is already high. Switching into
      // level mode after the fire does not create a new rising edge.
      always_comb begin
        w_trigNext = 1'b0;
        if (i_ena[g]) begin
          case (r_state)
            ST_IDLE, ST_COUNT: w_trigNext = w_match;
            ST_FIRED:          w_trigNext = r_trig && w_levelMode;
            default:           w_trigNext = 1'b0;
          endcase
        end
      end

      // Per-channel FSM with registered trigger, hit flag and counter.
      // A low enable sample discards the run from any state. In periodic
      // mode, the firing edge restarts the count at zero and stays in COUNT.
      // This makes later fires land on every further thresh-th high sample.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
          r_hit   <= 1'b0;
        end else begin
          r_trig <= w_trigNext;

          if (w_trigNext) begin
            r_hit <= 1'b1;
          end else if (i_hit_clr[g]) begin
            r_hit <= 1'b0;
          end

          if (!i_ena[g]) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            case (r_state)
              ST_IDLE, ST_COUNT: begin
                if (w_match) begin
                  if (w_periodicMode) begin
                    r_cnt   <= '0;
                    r_state <= ST_COUNT;
                  end else begin
                    r_cnt   <= w_nxt;
                    r_state <= ST_FIRED;
                  end
                end else begin
                  r_cnt   <= w_nxt;
                  r_state <= ST_COUNT;
                end
              end
              ST_FIRED: begin
                r_cnt   <= w_nxt;
                r_state <= ST_FIRED;
              end
              default: begin
                r_cnt   <= '0;
                r_state <= ST_IDLE;
              end
            endcase
          end
        end
      end

      assign o_trigger[g]                  = r_trig;
      assign o_hit[g]                      = r_hit;
      assign o_run_cnt[g*CNT_W +: CNT_W]   = r_cnt;

    end
  endgenerate

endmodule
